// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
package counter_sched_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int unsigned MAX_N     = 8;
    localparam int unsigned MAX_DWELL = 15;
    localparam int unsigned MAX_IW    = $clog2(MAX_N);

    // Index of the set bit in a one-hot vector; 0 when the vector is empty.
    function automatic logic [MAX_IW-1:0] onehot_to_index(input logic [MAX_N-1:0] onehot);
        logic [MAX_IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_N); i++) begin
            if (onehot[i]) idx = MAX_IW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  winner_c,
    output logic          found_c
);

    localparam int unsigned XW = IW + 1;

    logic [XW-1:0] idx;

    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        idx      = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = XW'(start) + XW'(k);
            if (idx >= XW'(N)) idx = idx - XW'(N);
            if (!found_c && req[idx[IW-1:0]]) begin
                winner_c[idx[IW-1:0]] = 1'b1;
                found_c               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// N counters sharing one +1 incrementer, granted round-robin with a fixed dwell.
module counter_scheduler
    import counter_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 2,
    parameter int unsigned DWELL = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         clear,
    output logic [N-1:0]         grant,
    output logic [N*WIDTH-1:0]   count,
    output logic [N-1:0]         wrap,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned DW = $clog2(MAX_DWELL + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    state_t            state, state_next;
    logic [N-1:0]      grant_next;
    logic [N-1:0]      winner;
    logic              found;
    logic [IW-1:0]     ptr, ptr_next;
    logic [IW-1:0]     holder, holder_succ, start;
    logic [DW-1:0]     dwell, dwell_next;
    logic              inc;
    logic [WIDTH-1:0]  cnt [N];

    assign holder      = IW'(onehot_to_index(MAX_N'(grant)));
    assign holder_succ = (holder == IW'(N - 1)) ? '0 : holder + IW'(1);
    // IDLE searches from the saved pointer; GRANT searches past the holder, holder last.
    assign start       = (state == IDLE) ? ptr : holder_succ;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req      (req),
        .start    (start),
        .winner_c (winner),
        .found_c  (found)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            dwell <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
            dwell <= dwell_next;
            busy  <= |grant_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        dwell_next = dwell;
        inc        = 1'b0;
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_next = winner;
                        state_next = GRANT;
                    end
                end
                GRANT: begin
                    if (req[holder]) begin
                        inc = 1'b1;
                        if (dwell == DWELL_LAST) begin
                            dwell_next = '0;
                            ptr_next   = holder_succ;
                            grant_next = winner;
                        end else begin
                            dwell_next = dwell + DW'(1);
                        end
                    end else begin
                        // Holder withdrew: hand over immediately, or fall back to IDLE.
                        dwell_next = '0;
                        ptr_next   = holder_succ;
                        grant_next = winner;
                        if (!found) state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Clear wins over a same-edge increment and suppresses its wrap pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) cnt[i] <= '0;
            wrap <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (clear[i]) begin
                    cnt[i] <= '0;
                end else if (inc && grant[i]) begin
                    cnt[i] <= cnt[i] + WIDTH'(1);
                end
                wrap[i] <= inc && grant[i] && !clear[i] && (&cnt[i]);
            end
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_count
        assign count[g*WIDTH +: WIDTH] = cnt[g];
    end

endmodule
